// File: rtl/issue_buffer_pkg.sv
// Shared issue definitions: one-hot unit codes, NOP uop, entry layout and a
// one-hot helper. The issue unit and issue_buffer both import this package.
package issue_buffer_pkg;

    localparam int unsigned SEL_W   = 4;
    localparam int unsigned UOP_W   = 4;
    localparam int unsigned ENTRY_W = 8;

    localparam logic [SEL_W-1:0] UNIT_INT = 4'b0001;
    localparam logic [SEL_W-1:0] UNIT_BRU = 4'b0010;
    localparam logic [SEL_W-1:0] UNIT_LSU = 4'b0100;
    localparam logic [SEL_W-1:0] UNIT_VEC = 4'b1000;
    localparam logic [SEL_W-1:0] UNIT_NONE = 4'b0000;

    localparam logic [UOP_W-1:0] UOP_NOP = 4'b0000;

    // Stored {unit select, uop} pair; sel occupies the upper nibble.
    typedef struct packed {
        logic [SEL_W-1:0] sel;
        logic [UOP_W-1:0] uop;
    } entry_t;

    // True when exactly one bit of the select is set.
    function automatic logic is_onehot(input logic [SEL_W-1:0] sel);
        return (sel != UNIT_NONE) && ((sel & (sel - SEL_W'(1))) == UNIT_NONE);
    endfunction

endpackage

// File: rtl/issue_buffer_fifo.sv
// DEPTH x ENTRY_W circular storage with read/write pointers and occupancy.
// Ports:
//   clk      core clock
//   clear    synchronous, active-high: drop all entries
//   push     write wr_data at the tail (caller guarantees !full)
//   pop      advance the head (caller guarantees !empty)
//   wr_data  entry to write
//   rd_data  current head entry (combinational from storage)
//   count    occupancy, 0..DEPTH
//   full     count == DEPTH
//   empty    count == 0
module issue_buffer_fifo
    import issue_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  entry_t           wr_data,
    output entry_t           rd_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign rd_data = mem[rd_ptr];
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);

endmodule

// File: rtl/issue_buffer.sv
// Decoded-uop buffer ahead of the issue unit. Queues {unit select, uop} pairs
// and presents the oldest one only when its execution unit is idle; otherwise
// drives an all-zero select. Strict in-order, one uop per cycle.
// Optional feature macro: ISSUE_BUF_BYPASS_EN -- an empty buffer passes an
// input whose unit is idle straight to the outputs in the same cycle.
// Ports:
//   clock_in           core clock
//   reset_in           synchronous, active-high reset
//   flush_in           synchronous discard of all entries
//   valid_in           decode presents a uop this cycle
//   exec_unit_sel_in   one-hot unit select (int/bru/lsu/vec)
//   exec_uop_in        unit-specific micro-op
//   ready_out          buffer can accept (not full)
//   unit_busy_in       per-unit busy, same bit order as the select
//   exec_unit_sel_out  select to issue unit, 0000 when nothing issues
//   exec_uop_out       uop to issue unit, 0000 when nothing issues
//   count_out          current occupancy
module issue_buffer
    import issue_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 3
) (
    input  logic             clock_in,
    input  logic             reset_in,
    input  logic             flush_in,
    input  logic             valid_in,
    input  logic [SEL_W-1:0] exec_unit_sel_in,
    input  logic [UOP_W-1:0] exec_uop_in,
    output logic             ready_out,
    input  logic [SEL_W-1:0] unit_busy_in,
    output logic [SEL_W-1:0] exec_unit_sel_out,
    output logic [UOP_W-1:0] exec_uop_out,
    output logic [CNT_W-1:0] count_out
);

    entry_t head;
    entry_t in_entry;
    logic   full;
    logic   empty;
    logic   clear;
    logic   sel_ok;
    logic   head_issue;
    logic   bypass;
    logic   push;

    assign clear    = reset_in | flush_in;
    assign sel_ok   = is_onehot(exec_unit_sel_in);
    assign in_entry = '{sel: exec_unit_sel_in, uop: exec_uop_in};

    // Head issues only if its unit is idle; clear cycles never issue.
    assign head_issue = !clear && !empty && ((head.sel & unit_busy_in) == UNIT_NONE);

`ifdef ISSUE_BUF_BYPASS_EN
    // Empty buffer: an idle-unit input goes straight out and is not stored.
    assign bypass = !clear && empty && valid_in && sel_ok &&
                    ((exec_unit_sel_in & unit_busy_in) == UNIT_NONE);
`else
    assign bypass = 1'b0;
`endif

    // ready_out ignores a same-cycle pop, so the full check is on current state.
    assign push = valid_in && !full && sel_ok && !clear && !bypass;

    issue_buffer_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk     (clock_in),
        .clear   (clear),
        .push    (push),
        .pop     (head_issue),
        .wr_data (in_entry),
        .rd_data (head),
        .count   (count_out),
        .full    (full),
        .empty   (empty)
    );

    assign ready_out = !full;

    // Output mux: stored head, bypassed input, or all-zero "no unit".
    always_comb begin
        exec_unit_sel_out = UNIT_NONE;
        exec_uop_out      = UOP_NOP;
        if (head_issue) begin
            exec_unit_sel_out = head.sel;
            exec_uop_out      = head.uop;
        end else if (bypass) begin
            exec_unit_sel_out = exec_unit_sel_in;
            exec_uop_out      = exec_uop_in;
        end
    end

endmodule
